cam_pixel_fifo: RTL and testbench

//  Parametrised camera capture FIFO, successor to the single-byte camera FIFO. Accepts bytes from the

---
 rtl/cam_pixel_fifo_if.sv | 45 ++++
 rtl/cam_pixel_fifo.sv | 143 ++++++++++++++
 tb/tb_cam_pixel_fifo.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/cam_pixel_fifo_if.sv
// cam_pixel_fifo_if
//   Groups the camera byte bus, the consumer read port and the status
//   outputs of cam_pixel_fifo.
//   master : capture front end / consumer side (drives the camera bytes,
//            rd and clr_ovf; observes the read data and the flags)
//   slave  : the FIFO itself
//   Signals:
//     pclk_en, href, vsync, din  camera byte stream
//     rd, dout, dout_valid       pop port (dout registered)
//     empty, full, almost_full   occupancy flags
//     count                      words stored (0..2**ABITS)
//     overflow, clr_ovf          sticky drop flag and its clear
//     sof                        start-of-frame pulse (vsync rising)
interface cam_pixel_fifo_if #(
  parameter int ABITS = 14,
  parameter int DBITS = 8,
  parameter int PACK  = 2
) ();
  localparam int OW = DBITS * PACK;

  logic             pclk_en;
  logic             href;
  logic             vsync;
  logic [DBITS-1:0] din;
  logic             rd;
  logic             clr_ovf;
  logic [OW-1:0]    dout;
  logic             dout_valid;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic [ABITS:0]   count;
  logic             overflow;
  logic             sof;

  modport master (
    output pclk_en, href, vsync, din, rd, clr_ovf,
    input  dout, dout_valid, empty, full, almost_full, count, overflow, sof
  );

  modport slave (
    input  pclk_en, href, vsync, din, rd, clr_ovf,
    output dout, dout_valid, empty, full, almost_full, count, overflow, sof
  );
endinterface

// File: rtl/cam_pixel_fifo.sv
// cam_pixel_fifo
//   Camera capture FIFO. Accepts href/vsync-qualified camera bytes on
//   pclk_en strobes, packs PACK bytes (first byte in the MSB slot) into one
//   word and stores up to 2**ABITS words. Occupancy is tracked by a true
//   counter, so every location is usable and full/empty come from count.
//   An optional flush empties the FIFO on each vsync rising edge.
//   Ports:
//     clk    system clock (single domain)
//     reset  asynchronous, active-low reset
//     bus    cam_pixel_fifo_if.slave (byte stream, pop port, flags)
module cam_pixel_fifo #(
  parameter int ABITS          = 14,
  parameter int DBITS          = 8,
  parameter int PACK           = 2,
  parameter int AF_LEVEL       = 2**ABITS - 4,
  parameter int FLUSH_ON_VSYNC = 1
) (
  input  logic             clk,
  input  logic             reset,
  cam_pixel_fifo_if.slave  bus
);
  localparam int OW    = DBITS * PACK;
  localparam int DEPTH = 2**ABITS;
  localparam logic [ABITS:0] FULL_CNT = (ABITS+1)'(DEPTH);
  localparam logic [ABITS:0] AF_CNT   = (ABITS+1)'(AF_LEVEL);

  logic [OW-1:0]    mem [DEPTH];
  logic [ABITS-1:0] wr_ptr;
  logic [ABITS-1:0] rd_ptr;
  logic [ABITS:0]   count_r;
  logic [ABITS:0]   count_nxt;
  logic             byte_cnt;
  logic [OW-1:0]    pack_reg;
  logic [OW-1:0]    word;
  logic             vsync_q;
  logic             sof;
  logic             flush;
  logic             accept;
  logic             last_byte;
  logic             push;
  logic             push_ok;
  logic             pop_ok;
  logic             drop;
  logic             empty_r;
  logic             full_r;
  logic             af_r;
  logic             dv_r;
  logic             ovf_r;
  logic [OW-1:0]    dout_r;

  assign sof       = bus.vsync & ~vsync_q;
  assign flush     = (FLUSH_ON_VSYNC != 0) && sof;
  assign accept    = bus.pclk_en & bus.href & ~bus.vsync;
  // PACK is 1 or 2, so a single bit is enough to count bytes within a word.
  assign last_byte = (PACK == 1) || byte_cnt;
  assign push      = accept & last_byte;
  // Pop looks at the registered empty flag, so a push into an empty FIFO
  // is never read through in the same cycle. A flush cancels any pop.
  assign pop_ok    = bus.rd & ~empty_r & ~flush;
  assign push_ok   = push & (~full_r | pop_ok) & ~flush;
  assign drop      = push & ~push_ok;

  // The last byte lands in the LSB slot; earlier bytes sit in pack_reg.
  always_comb begin
    word            = pack_reg;
    word[DBITS-1:0] = bus.din;
  end

  always_comb begin
    count_nxt = count_r;
    if (flush) begin
      count_nxt = '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count_nxt = count_r + 1'b1;
        2'b01:   count_nxt = count_r - 1'b1;
        default: count_nxt = count_r;
      endcase
    end
  end

  // Storage array carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_r  <= '0;
      byte_cnt <= 1'b0;
      pack_reg <= '0;
      vsync_q  <= 1'b0;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
      af_r     <= 1'b0;
      dv_r     <= 1'b0;
      ovf_r    <= 1'b0;
      dout_r   <= '0;
    end else begin
      vsync_q <= bus.vsync;
      count_r <= count_nxt;
      empty_r <= (count_nxt == '0);
      full_r  <= (count_nxt == FULL_CNT);
      af_r    <= (count_nxt >= AF_CNT);
      dv_r    <= pop_ok;
      if (pop_ok) dout_r <= mem[rd_ptr];

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end

      if (drop)             ovf_r <= 1'b1;
      else if (bus.clr_ovf) ovf_r <= 1'b0;

      // A partial word is abandoned when the line ends or blanking starts.
      if ((bus.pclk_en & ~bus.href) | bus.vsync) begin
        byte_cnt <= 1'b0;
        pack_reg <= '0;
      end else if (push) begin
        byte_cnt <= 1'b0;
        pack_reg <= '0;
      end else if (accept) begin
        byte_cnt                <= 1'b1;
        pack_reg[OW-1 -: DBITS] <= bus.din;
      end
    end
  end

  assign bus.dout        = dout_r;
  assign bus.dout_valid  = dv_r;
  assign bus.empty       = empty_r;
  assign bus.full        = full_r;
  assign bus.almost_full = af_r;
  assign bus.count       = count_r;
  assign bus.overflow    = ovf_r;
  assign bus.sof         = sof;
endmodule

// File: tb/tb_cam_pixel_fifo.sv
module tb_cam_pixel_fifo;
  localparam int ABITS = 3;
  localparam int DBITS = 8;
  localparam int PACK  = 2;
  localparam int NVEC  = 24;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  cam_pixel_fifo_if #(.ABITS(ABITS), .DBITS(DBITS), .PACK(PACK)) bus ();

  cam_pixel_fifo #(
    .ABITS(ABITS), .DBITS(DBITS), .PACK(PACK), .AF_LEVEL(4), .FLUSH_ON_VSYNC(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pclk_en;
    logic        href;
    logic        vsync;
    logic [7:0]  din;
    logic        rd;
    logic        clr_ovf;
    logic [3:0]  cnt;
    logic        empty;
    logic        dv;
    logic [15:0] dout;
    logic        ovf;
    logic        sof;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic pe, input logic hr, input logic vs,
                              input logic [7:0] d, input logic r, input logic co,
                              input logic [3:0] c, input logic e, input logic v,
                              input logic [15:0] q, input logic o, input logic s);
    vec_t t;
    t.pclk_en = pe; t.href = hr; t.vsync = vs; t.din = d; t.rd = r; t.clr_ovf = co;
    t.cnt = c; t.empty = e; t.dv = v; t.dout = q; t.ovf = o; t.sof = s;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic put_byte(input logic [7:0] b);
    bus.href    = 1'b1;
    bus.pclk_en = 1'b1;
    bus.din     = b;
    cycle();
    bus.pclk_en = 1'b0;
  endtask

  task automatic push_word(input logic [15:0] w);
    put_byte(w[15:8]);
    put_byte(w[7:0]);
  endtask

  task automatic pop_check(input string name, input logic [15:0] exp);
    bus.rd = 1'b1;
    cycle();
    bus.rd = 1'b0;
    check({name, "_valid"}, 32'(bus.dout_valid), 32'(1'b1));
    check({name, "_data"}, 32'(bus.dout), 32'(exp));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset       = 1'b0;
    bus.pclk_en = 1'b0;
    bus.href    = 1'b0;
    bus.vsync   = 1'b0;
    bus.din     = '0;
    bus.rd      = 1'b0;
    bus.clr_ovf = 1'b0;

    //           pe hr vs din    rd co  cnt e  dv dout      ov sof
    vecs[0]  = mk(0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 16'h0000, 0, 0);
    vecs[1]  = mk(1, 1, 0, 8'hAB, 0, 0, 0, 1, 0, 16'h0000, 0, 0);
    vecs[2]  = mk(0, 1, 0, 8'h00, 0, 0, 0, 1, 0, 16'h0000, 0, 0);
    vecs[3]  = mk(1, 1, 0, 8'hCD, 0, 0, 1, 0, 0, 16'h0000, 0, 0);
    vecs[4]  = mk(0, 1, 0, 8'h00, 1, 0, 0, 1, 1, 16'hABCD, 0, 0);
    vecs[5]  = mk(0, 0, 0, 8'h00, 1, 0, 0, 1, 0, 16'hABCD, 0, 0);
    vecs[6]  = mk(1, 1, 0, 8'h11, 0, 0, 0, 1, 0, 16'hABCD, 0, 0);
    vecs[7]  = mk(1, 0, 0, 8'h99, 0, 0, 0, 1, 0, 16'hABCD, 0, 0);
    vecs[8]  = mk(1, 1, 0, 8'h22, 0, 0, 0, 1, 0, 16'hABCD, 0, 0);
    vecs[9]  = mk(1, 1, 0, 8'h33, 0, 0, 1, 0, 0, 16'hABCD, 0, 0);
    vecs[10] = mk(0, 0, 0, 8'h00, 1, 0, 0, 1, 1, 16'h2233, 0, 0);
    vecs[11] = mk(1, 1, 0, 8'h44, 0, 0, 0, 1, 0, 16'h2233, 0, 0);
    vecs[12] = mk(1, 1, 0, 8'h55, 1, 0, 1, 0, 0, 16'h2233, 0, 0);
    vecs[13] = mk(0, 1, 0, 8'h00, 1, 0, 0, 1, 1, 16'h4455, 0, 0);
    vecs[14] = mk(1, 1, 0, 8'h66, 0, 0, 0, 1, 0, 16'h4455, 0, 0);
    vecs[15] = mk(0, 0, 1, 8'h00, 0, 0, 0, 1, 0, 16'h4455, 0, 1);
    vecs[16] = mk(0, 0, 1, 8'h00, 0, 0, 0, 1, 0, 16'h4455, 0, 0);
    vecs[17] = mk(0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 16'h4455, 0, 0);
    vecs[18] = mk(1, 1, 0, 8'h77, 0, 0, 0, 1, 0, 16'h4455, 0, 0);
    vecs[19] = mk(1, 1, 0, 8'h88, 0, 0, 1, 0, 0, 16'h4455, 0, 0);
    vecs[20] = mk(0, 1, 0, 8'h00, 1, 0, 0, 1, 1, 16'h7788, 0, 0);
    vecs[21] = mk(1, 1, 1, 8'hAA, 0, 0, 0, 1, 0, 16'h7788, 0, 1);
    vecs[22] = mk(1, 1, 1, 8'hBB, 0, 0, 0, 1, 0, 16'h7788, 0, 0);
    vecs[23] = mk(0, 0, 0, 8'h00, 1, 0, 0, 1, 0, 16'h7788, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("rst_empty", 32'(bus.empty), 32'(1'b1));
    check("rst_count", 32'(bus.count), 32'(0));
    check("rst_dout", 32'(bus.dout), 32'(0));
    check("rst_ovf", 32'(bus.overflow), 32'(1'b0));
    @(negedge clk);
    reset = 1'b1;
    cycle();

    // Table: packing, partial word, push+pop on empty, vsync discard.
    for (int i = 0; i < NVEC; i++) begin
      bus.pclk_en = vecs[i].pclk_en;
      bus.href    = vecs[i].href;
      bus.vsync   = vecs[i].vsync;
      bus.din     = vecs[i].din;
      bus.rd      = vecs[i].rd;
      bus.clr_ovf = vecs[i].clr_ovf;
      #1;
      check($sformatf("v%0d_sof", i), 32'(bus.sof), 32'(vecs[i].sof));
      cycle();
      check($sformatf("v%0d_count", i), 32'(bus.count), 32'(vecs[i].cnt));
      check($sformatf("v%0d_empty", i), 32'(bus.empty), 32'(vecs[i].empty));
      check($sformatf("v%0d_dv", i), 32'(bus.dout_valid), 32'(vecs[i].dv));
      check($sformatf("v%0d_dout", i), 32'(bus.dout), 32'(vecs[i].dout));
      check($sformatf("v%0d_ovf", i), 32'(bus.overflow), 32'(vecs[i].ovf));
    end
    bus.pclk_en = 1'b0; bus.href = 1'b0; bus.vsync = 1'b0; bus.rd = 1'b0;
    cycle();

    // Fill to full, overflow, set-beats-clear, drain in order.
    for (int i = 1; i <= 8; i++) begin
      push_word(16'(i));
      if (i == 3) check("af_at_3", 32'(bus.almost_full), 32'(1'b0));
      if (i == 4) check("af_at_4", 32'(bus.almost_full), 32'(1'b1));
    end
    check("fill_full", 32'(bus.full), 32'(1'b1));
    check("fill_count", 32'(bus.count), 32'(8));
    check("fill_af", 32'(bus.almost_full), 32'(1'b1));
    check("fill_ovf0", 32'(bus.overflow), 32'(1'b0));
    push_word(16'h0909);
    check("ovf_set", 32'(bus.overflow), 32'(1'b1));
    check("ovf_count", 32'(bus.count), 32'(8));
    put_byte(8'h0A);
    bus.clr_ovf = 1'b1;
    put_byte(8'h0B);
    bus.clr_ovf = 1'b0;
    check("ovf_set_beats_clr", 32'(bus.overflow), 32'(1'b1));
    for (int i = 1; i <= 8; i++) pop_check($sformatf("fill_pop%0d", i), 16'(i));
    check("drain_empty", 32'(bus.empty), 32'(1'b1));
    check("drain_full", 32'(bus.full), 32'(1'b0));
    bus.clr_ovf = 1'b1;
    cycle();
    bus.clr_ovf = 1'b0;
    check("ovf_clr", 32'(bus.overflow), 32'(1'b0));

    // Pointer wrap and push+pop while full.
    for (int i = 0; i < 5; i++) push_word(16'h0010 + 16'(i));
    for (int i = 0; i < 3; i++) pop_check($sformatf("wrap_pop%0d", i), 16'h0010 + 16'(i));
    for (int i = 5; i < 11; i++) push_word(16'h0010 + 16'(i));
    check("wrap_full", 32'(bus.full), 32'(1'b1));
    put_byte(8'h00);
    bus.rd = 1'b1;
    put_byte(8'h1B);
    bus.rd = 1'b0;
    check("simul_count", 32'(bus.count), 32'(8));
    check("simul_ovf", 32'(bus.overflow), 32'(1'b0));
    check("simul_dv", 32'(bus.dout_valid), 32'(1'b1));
    check("simul_dout", 32'(bus.dout), 32'(16'h0013));
    for (int i = 4; i < 12; i++) pop_check($sformatf("wrap_drain%0d", i), 16'h0010 + 16'(i));
    check("wrap_empty", 32'(bus.empty), 32'(1'b1));

    // Frame flush with a concurrent pop request.
    for (int i = 1; i <= 3; i++) push_word(16'h0020 + 16'(i));
    check("flush_pre_count", 32'(bus.count), 32'(3));
    bus.href  = 1'b0;
    bus.vsync = 1'b1;
    bus.rd    = 1'b1;
    #1;
    check("flush_sof", 32'(bus.sof), 32'(1'b1));
    cycle();
    bus.rd = 1'b0;
    check("flush_count", 32'(bus.count), 32'(0));
    check("flush_empty", 32'(bus.empty), 32'(1'b1));
    check("flush_dv", 32'(bus.dout_valid), 32'(1'b0));
    check("flush_dout_hold", 32'(bus.dout), 32'(16'h001B));
    check("flush_sof_done", 32'(bus.sof), 32'(1'b0));
    bus.vsync = 1'b0;
    cycle();

    // Asynchronous reset in the middle of a cycle.
    for (int i = 1; i <= 6; i++) push_word(16'h0030 + 16'(i));
    pop_check("rst_pre_pop", 16'h0031);
    check("rst_pre_count", 32'(bus.count), 32'(5));
    #2;
    reset = 1'b0;
    #1;
    check("async_count", 32'(bus.count), 32'(0));
    check("async_empty", 32'(bus.empty), 32'(1'b1));
    check("async_af", 32'(bus.almost_full), 32'(1'b0));
    check("async_dv", 32'(bus.dout_valid), 32'(1'b0));
    check("async_dout", 32'(bus.dout), 32'(0));
    @(negedge clk);
    reset = 1'b1;
    bus.rd = 1'b1;
    cycle();
    bus.rd = 1'b0;
    check("post_rst_rd_dv", 32'(bus.dout_valid), 32'(1'b0));
    check("post_rst_empty", 32'(bus.empty), 32'(1'b1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
